// File: rtl/uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one UART transmitter between two producers: a register-file read
// port (one byte per request) and an ALU result port (two bytes per
// request, low byte first). Each accepted request becomes a frame of one
// or two single-cycle TX_DATA_VALID strobes. After every strobe the
// scheduler waits for the transmitter to go busy and then idle again
// before presenting the next byte or returning to IDLE.
//
// Ports
//   CLK            rising-edge clock
//   RST            synchronous, active-high reset
//   RF_RD_DATA     byte from the register file
//   RF_RD_VALID    RF_RD_DATA is valid
//   RF_RD_READY    RF request accepted this cycle
//   ALU_OUT        two-byte ALU result
//   ALU_VALID      ALU_OUT is valid
//   ALU_READY      ALU request accepted this cycle
//   TX_BUSY        transmitter busy flag (synchronous to CLK)
//   TX_P_DATA      byte presented to the transmitter
//   TX_DATA_VALID  one-cycle load strobe for TX_P_DATA
//   SCHED_BUSY     high whenever the FSM is not in IDLE
//   DBG_STATE      current FSM state, for observation only
//
// Handshake: a request transfers on a rising edge where its VALID and
// READY are both high. READY is only offered in IDLE, while the
// transmitter is idle and reset is low; it depends combinationally on
// VALID so that at most one READY is ever high. The producer must hold
// VALID and data stable until it sees READY; once accepted the data is
// captured and later input changes do not affect the frame.
// ---------------------------------------------------------------------------
module uart_tx_scheduler #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [DATA_WIDTH-1:0]   RF_RD_DATA,
  input  logic                    RF_RD_VALID,
  output logic                    RF_RD_READY,
  input  logic [2*DATA_WIDTH-1:0] ALU_OUT,
  input  logic                    ALU_VALID,
  output logic                    ALU_READY,
  input  logic                    TX_BUSY,
  output logic [DATA_WIDTH-1:0]   TX_P_DATA,
  output logic                    TX_DATA_VALID,
  output logic                    SCHED_BUSY,
  output logic [1:0]              DBG_STATE
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_WAIT_HI = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  // Bytes of the current frame not yet strobed.
  logic [1:0]            r_byte_cnt;
  // 1 when the most recent grant went to the ALU; reset value makes the
  // register file win the first contested arbitration.
  logic                  r_last_alu;
  // High byte of an accepted ALU result, waiting for its turn.
  logic [DATA_WIDTH-1:0] r_hi_byte;
  // Byte on TX_P_DATA; loaded on the edge that enters LOAD and held
  // everywhere else.
  logic [DATA_WIDTH-1:0] r_tx_data;

  logic                  w_can_accept;
  logic                  w_grant_rf;
  logic                  w_grant_alu;
  logic                  w_load_next;

  // -------------------------------------------------------------------------
  // Arbitration. With both requesters valid, the one not granted last wins.
  // -------------------------------------------------------------------------
  always_comb begin
    w_can_accept = (r_state == S_IDLE) && !TX_BUSY && !RST;
    w_grant_rf   = w_can_accept && RF_RD_VALID && (!ALU_VALID || r_last_alu);
    w_grant_alu  = w_can_accept && ALU_VALID && (!RF_RD_VALID || !r_last_alu);
    // Transmitter has finished the previous byte and another is pending.
    w_load_next  = (r_state == S_WAIT_LO) && !TX_BUSY && (r_byte_cnt != 2'd0);
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_rf || w_grant_alu) begin
          w_next_state = S_LOAD;
        end
      end
      S_LOAD: begin
        w_next_state = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // The transmitter must acknowledge the strobe by going busy.
        if (TX_BUSY) begin
          w_next_state = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (!TX_BUSY) begin
          if (r_byte_cnt != 2'd0) begin
            w_next_state = S_LOAD;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    RF_RD_READY   = w_grant_rf;
    ALU_READY     = w_grant_alu;
    TX_DATA_VALID = (r_state == S_LOAD);
    SCHED_BUSY    = (r_state != S_IDLE);
    DBG_STATE     = r_state;
  end

  assign TX_P_DATA = r_tx_data;

  // -------------------------------------------------------------------------
  // Datapath: request capture, byte sequencing and grant history.
  // -------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_byte_cnt <= 2'd0;
      r_last_alu <= 1'b1;
      r_hi_byte  <= '0;
      r_tx_data  <= '0;
    end else begin
      if (w_grant_rf) begin
        r_tx_data  <= RF_RD_DATA;
        r_byte_cnt <= 2'd1;
        r_last_alu <= 1'b0;
      end else if (w_grant_alu) begin
        r_tx_data  <= ALU_OUT[DATA_WIDTH-1:0];
        r_hi_byte  <= ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH];
        r_byte_cnt <= 2'd2;
        r_last_alu <= 1'b1;
      end else if (r_state == S_LOAD) begin
        // The byte on TX_P_DATA is consumed by this strobe.
        r_byte_cnt <= r_byte_cnt - 2'd1;
      end else if (w_load_next) begin
        r_tx_data  <= r_hi_byte;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Bench for uart_tx_scheduler. A small UART model raises TX_BUSY for
// busy_len cycles after each strobe. A per-cycle reference model, written
// as frame-level rules (bytes outstanding, busy seen high / low, grant
// history), predicts READY, TX_DATA_VALID, TX_P_DATA and SCHED_BUSY; a byte
// queue holds the expected transmit order.
// ---------------------------------------------------------------------------
module tb_uart_tx_scheduler;

  localparam int W = 8;

  // ---------------- clock / reset / DUT signals ----------------
  logic           CLK = 1'b0;
  logic           RST = 1'b1;
  logic [W-1:0]   RF_RD_DATA = '0;
  logic           RF_RD_VALID = 1'b0;
  logic           RF_RD_READY;
  logic [2*W-1:0] ALU_OUT = '0;
  logic           ALU_VALID = 1'b0;
  logic           ALU_READY;
  logic           TX_BUSY;
  logic [W-1:0]   TX_P_DATA;
  logic           TX_DATA_VALID;
  logic           SCHED_BUSY;
  logic [1:0]     DBG_STATE;

  always #5 CLK = ~CLK;

  uart_tx_scheduler #(.DATA_WIDTH(W)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .RF_RD_DATA    (RF_RD_DATA),
    .RF_RD_VALID   (RF_RD_VALID),
    .RF_RD_READY   (RF_RD_READY),
    .ALU_OUT       (ALU_OUT),
    .ALU_VALID     (ALU_VALID),
    .ALU_READY     (ALU_READY),
    .TX_BUSY       (TX_BUSY),
    .TX_P_DATA     (TX_P_DATA),
    .TX_DATA_VALID (TX_DATA_VALID),
    .SCHED_BUSY    (SCHED_BUSY),
    .DBG_STATE     (DBG_STATE)
  );

  // ---------------- UART transmitter model ----------------
  int   busy_len   = 10;
  int   busy_cnt   = 0;
  logic force_busy = 1'b0;

  always @(posedge CLK) begin
    if (TX_DATA_VALID) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  assign TX_BUSY = (busy_cnt != 0) || force_busy;

  // ---------------- counters and check tasks ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chk_d(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard / reference model ----------------
  logic         mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  logic         d_log[$];          // DUT grants: 0 = RF, 1 = ALU
  int           m_left     = 0;    // bytes of the frame not yet strobed
  logic         m_due      = 1'b0; // a strobe is required this cycle
  logic         m_wait     = 1'b0; // between a strobe and the busy low
  logic         m_seen_hi  = 1'b0; // transmitter went busy since strobe
  logic         m_in_frame = 1'b0;
  logic         m_last_alu = 1'b1;
  logic [W-1:0] m_last_data = '0;
  logic         e_idle, e_rf, e_alu;
  logic [W-1:0] e_byte;

  always @(negedge CLK) begin
    if (mon_en) begin
      e_idle = !m_in_frame && !TX_BUSY && !RST;
      e_rf   = e_idle && RF_RD_VALID && (!ALU_VALID || m_last_alu);
      e_alu  = e_idle && ALU_VALID && (!RF_RD_VALID || !m_last_alu);
      chk_b("rf_ready", RF_RD_READY, e_rf);
      chk_b("alu_ready", ALU_READY, e_alu);
      chk_b("sched_busy", SCHED_BUSY, m_in_frame);
      chk_b("tx_valid", TX_DATA_VALID, m_due);
      if (m_due) begin
        if (exp_q.size() == 0) begin
          chk_b("sb_underflow", 1'b1, 1'b0);
        end else begin
          e_byte = exp_q.pop_front();
          chk_d("tx_byte", TX_P_DATA, e_byte);
          m_last_data = e_byte;
        end
      end else begin
        chk_d("tx_hold", TX_P_DATA, m_last_data);
      end
      if (RF_RD_READY && RF_RD_VALID) d_log.push_back(1'b0);
      else if (ALU_READY && ALU_VALID) d_log.push_back(1'b1);

      if (RST) begin
        exp_q.delete();
        m_left = 0; m_due = 1'b0; m_wait = 1'b0; m_seen_hi = 1'b0;
        m_in_frame = 1'b0; m_last_alu = 1'b1; m_last_data = '0;
      end else begin
        if (m_due) begin
          m_due = 1'b0; m_left--; m_wait = 1'b1; m_seen_hi = 1'b0;
        end else if (m_wait) begin
          if (!m_seen_hi) begin
            if (TX_BUSY) m_seen_hi = 1'b1;
          end else if (!TX_BUSY) begin
            m_wait = 1'b0;
            if (m_left > 0) m_due = 1'b1;
            else m_in_frame = 1'b0;
          end
        end
        if (e_rf) begin
          exp_q.push_back(RF_RD_DATA);
          m_left = 1; m_due = 1'b1; m_in_frame = 1'b1; m_last_alu = 1'b0;
        end else if (e_alu) begin
          exp_q.push_back(ALU_OUT[W-1:0]);
          exp_q.push_back(ALU_OUT[2*W-1:W]);
          m_left = 2; m_due = 1'b1; m_in_frame = 1'b1; m_last_alu = 1'b1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (TX_BUSY === lvl) begin
        hit = 1'b1;
        break;
      end
    end
    chk_b(tag, hit, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (!SCHED_BUSY && !TX_BUSY) begin
        hit = 1'b1;
        break;
      end
    end
    chk_b(tag, hit, 1'b1);
    tick();
  endtask

  // ---------------- directed and random stimulus ----------------
  logic [3:0] exp_order;
  logic       found;

  initial begin
    // Reset, with both requesters valid: no READY may appear.
    RST = 1'b1; RF_RD_VALID = 1'b1; ALU_VALID = 1'b1;
    tick();
    mon_en = 1'b1;
    tick();
    @(negedge CLK);
    chk_b("rst_tx_valid", TX_DATA_VALID, 1'b0);
    chk_d("rst_tx_data", TX_P_DATA, 8'h00);
    chk_b("rst_sched_busy", SCHED_BUSY, 1'b0);
    chk_b("rst_rf_ready", RF_RD_READY, 1'b0);
    chk_b("rst_alu_ready", ALU_READY, 1'b0);
    tick();
    RF_RD_VALID = 1'b0; ALU_VALID = 1'b0; RST = 1'b0;

    // Single RF byte.
    RF_RD_DATA = 8'hA5; RF_RD_VALID = 1'b1;
    @(negedge CLK);
    chk_b("rf_accept", RF_RD_READY, 1'b1);
    tick();
    RF_RD_VALID = 1'b0; RF_RD_DATA = 8'h00;
    @(negedge CLK);
    chk_b("rf_strobe", TX_DATA_VALID, 1'b1);
    chk_d("rf_byte", TX_P_DATA, 8'hA5);
    wait_busy(1'b1, 5, "rf_busy_rise");
    wait_busy(1'b0, 30, "rf_busy_fall");
    chk_b("rf_sched_busy_hold", SCHED_BUSY, 1'b1);
    @(negedge CLK);
    chk_b("rf_sched_busy_fall", SCHED_BUSY, 1'b0);
    tick();

    // Two-byte ALU frame, low byte first.
    ALU_OUT = 16'h1234; ALU_VALID = 1'b1;
    @(negedge CLK);
    chk_b("alu_accept", ALU_READY, 1'b1);
    tick();
    ALU_VALID = 1'b0;
    @(negedge CLK);
    chk_b("alu_strobe1", TX_DATA_VALID, 1'b1);
    chk_d("alu_byte1", TX_P_DATA, 8'h34);
    wait_busy(1'b1, 5, "alu_busy_rise");
    wait_busy(1'b0, 30, "alu_busy_fall");
    @(negedge CLK);
    chk_b("alu_strobe2", TX_DATA_VALID, 1'b1);
    chk_d("alu_byte2", TX_P_DATA, 8'h12);
    wait_idle(40, "alu_idle");

    // Input changes after acceptance must not alter the frame.
    ALU_OUT = 16'h1234; ALU_VALID = 1'b1;
    tick();
    ALU_OUT = 16'hFFFF; ALU_VALID = 1'b0;
    @(negedge CLK);
    chk_d("hold_byte1", TX_P_DATA, 8'h34);
    wait_busy(1'b1, 5, "hold_busy_rise");
    wait_busy(1'b0, 30, "hold_busy_fall");
    @(negedge CLK);
    chk_d("hold_byte2", TX_P_DATA, 8'h12);
    wait_idle(40, "hold_idle");

    // Round-robin after reset: RF, ALU, RF, ALU.
    RST = 1'b1;
    tick();
    RST = 1'b0;
    d_log.delete();
    RF_RD_DATA = 8'h5A; RF_RD_VALID = 1'b1;
    ALU_OUT = 16'hBEEF; ALU_VALID = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (d_log.size() >= 4) begin
        found = 1'b1;
        break;
      end
    end
    chk_b("rr_four_grants", found, 1'b1);
    tick();
    RF_RD_VALID = 1'b0; ALU_VALID = 1'b0;
    exp_order = 4'b1010;
    if (found) begin
      for (int i = 0; i < 4; i++) chk_b("rr_order", d_log[i], exp_order[i]);
    end
    wait_idle(60, "rr_idle");

    // TX_BUSY high in IDLE blocks acceptance.
    force_busy = 1'b1;
    RF_RD_DATA = 8'h3C; RF_RD_VALID = 1'b1;
    repeat (5) begin
      @(negedge CLK);
      chk_b("busy_block", RF_RD_READY, 1'b0);
    end
    tick();
    force_busy = 1'b0;
    @(negedge CLK);
    chk_b("busy_release", RF_RD_READY, 1'b1);
    tick();
    RF_RD_VALID = 1'b0;
    wait_idle(40, "busy_idle");

    // Reset in WAIT_LO between ALU bytes aborts the frame.
    ALU_OUT = 16'hCAFE; ALU_VALID = 1'b1;
    tick();
    ALU_VALID = 1'b0;
    wait_busy(1'b1, 5, "abort_busy_rise");
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    @(negedge CLK);
    chk_b("abort_tx_valid", TX_DATA_VALID, 1'b0);
    chk_d("abort_tx_data", TX_P_DATA, 8'h00);
    chk_b("abort_sched_busy", SCHED_BUSY, 1'b0);
    chk_b("abort_alu_ready", ALU_READY, 1'b0);
    repeat (15) begin
      @(negedge CLK);
      chk_b("abort_no_strobe", TX_DATA_VALID, 1'b0);
    end
    wait_idle(40, "abort_idle");
    RF_RD_DATA = 8'h77; RF_RD_VALID = 1'b1;
    tick();
    RF_RD_VALID = 1'b0;
    @(negedge CLK);
    chk_b("post_abort_strobe", TX_DATA_VALID, 1'b1);
    chk_d("post_abort_byte", TX_P_DATA, 8'h77);
    wait_idle(40, "post_abort_idle");

    // Random traffic, transmitter timing, busy glitches and resets.
    for (int c = 0; c < 1500; c++) begin
      if ((c % 100) == 0) busy_len = int'($urandom_range(1, 12));
      RF_RD_VALID = ($urandom_range(0, 2) == 0);
      RF_RD_DATA  = W'($urandom);
      ALU_VALID   = ($urandom_range(0, 2) == 0);
      ALU_OUT     = (2*W)'($urandom);
      force_busy  = ($urandom_range(0, 15) == 0);
      RST         = ($urandom_range(0, 199) == 0);
      tick();
    end
    RST = 1'b0; RF_RD_VALID = 1'b0; ALU_VALID = 1'b0; force_busy = 1'b0;
    wait_idle(100, "final_idle");
    chk_b("sb_drained", exp_q.size() == 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, the UART byte width.
REQ-002 The block SHALL have port CLK  input  1  the single clock; all logic is rising-edge.
REQ-003 The block SHALL have port RST  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port RF_RD_DATA  input  DATA_WIDTH  register-file read byte to transmit.
REQ-005 The block SHALL have port RF_RD_VALID  input  1  RF_RD_DATA is valid.
REQ-006 The block SHALL have port RF_RD_READY  output  1  scheduler accepts the RF request this cycle.
REQ-007 The block SHALL have port ALU_OUT  input  2*DATA_WIDTH  ALU result to transmit as two bytes.
REQ-008 The block SHALL have port ALU_VALID  input  1  ALU_OUT is valid.
REQ-009 The block SHALL have port ALU_READY  output  1  scheduler accepts the ALU request this cycle.
REQ-010 The block SHALL have port TX_BUSY  input  1  UART transmitter busy flag, synchronous to CLK.
REQ-011 The block SHALL have port TX_P_DATA  output  DATA_WIDTH  byte presented to the UART transmitter.
REQ-012 The block SHALL have port TX_DATA_VALID  output  1  single-cycle strobe loading TX_P_DATA.
REQ-013 The block SHALL have port SCHED_BUSY  output  1  high in every state except IDLE.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, WAIT_HI and WAIT_LO, all registered.
REQ-015 In IDLE, RF_RD_READY and ALU_READY SHALL be driven combinationally; at most one SHALL be high in any cycle.
REQ-016 A request SHALL be accepted in the cycle where VALID and READY are both high; accepted data SHALL be captured into internal registers that same edge.
REQ-017 In IDLE with TX_BUSY high, both READY outputs SHALL be low (no acceptance).
REQ-018 With one VALID high in IDLE and TX_BUSY low, that requester SHALL be granted.
REQ-019 With both VALID high, grant SHALL be round-robin: the requester not granted last wins; the last-grant flag after reset SHALL select RF first.
REQ-020 On acceptance the FSM SHALL go to LOAD with byte count 1 (RF) or 2 (ALU).
REQ-021 In LOAD, TX_DATA_VALID SHALL be high for exactly one cycle with TX_P_DATA = current byte; ALU order SHALL be ALU_OUT[DATA_WIDTH-1:0] first, then ALU_OUT[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-022 Latency: TX_DATA_VALID SHALL rise the cycle after acceptance.
REQ-023 LOAD SHALL go to WAIT_HI unconditionally; WAIT_HI SHALL stay until TX_BUSY = 1, then go to WAIT_LO.
REQ-024 WAIT_LO SHALL stay until TX_BUSY = 0; then if bytes remain go to LOAD (next byte, one cycle later), else go to IDLE.
REQ-025 TX_P_DATA SHALL hold its last value outside LOAD; TX_DATA_VALID SHALL be 0 outside LOAD.
REQ-026 Input VALID/data changes after acceptance SHALL NOT affect the frame in progress.
REQ-027 The first acceptance possible after a frame SHALL be the cycle after return to IDLE (no acceptance in the IDLE-entry cycle's WAIT_LO).

Reset
REQ-028 RST high at any rising edge SHALL force IDLE, byte count 0, last-grant = ALU (so RF wins next), TX_DATA_VALID = 0, TX_P_DATA = 0, SCHED_BUSY = 0.
REQ-029 RST asserted mid-frame SHALL abort the frame; the pending byte SHALL NOT be strobed after reset releases.
REQ-030 READY outputs SHALL be low while RST is high.

Verification
REQ-031 RF_RD_DATA=0xA5, RF_RD_VALID one cycle, TX_BUSY model 10 cycles -> RF_RD_READY high that cycle, TX_DATA_VALID next cycle with 0xA5, SCHED_BUSY falls one cycle after TX_BUSY falls.
REQ-032 ALU_OUT=0x1234, ALU_VALID -> two TX_DATA_VALID strobes, 0x34 then 0x12, second strobe one cycle after TX_BUSY falls.
REQ-033 RF_RD_VALID and ALU_VALID both held high after reset -> grant order RF, ALU, RF, ALU; never both READY.
REQ-034 TX_BUSY held high while IDLE with RF_RD_VALID=1 -> RF_RD_READY=0 until TX_BUSY=0, then accept.
REQ-035 RST pulsed in WAIT_LO between ALU bytes -> no second strobe, all outputs at reset values, next request served normally.
REQ-036 ALU_OUT changed to 0xFFFF one cycle after acceptance of 0x1234 -> transmitted bytes remain 0x34, 0x12.
